// File: rtl/updo_seq_pkg.sv
// Shared types for the up/down counter stimulus sequencer: command opcodes,
// the command record, FSM states and the op-to-pin mapping.
package updo_seq_pkg;

  localparam int CMD_LEN_W = 8;

  typedef enum logic [1:0] {
    OP_UP   = 2'b00,
    OP_DOWN = 2'b01,
    OP_RST  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [CMD_LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Returns {cnt_rst, updo} for an op; anything not UP/DOWN parks the counter.
  function automatic logic [1:0] drive_for(input op_e op);
    case (op)
      OP_UP:   return 2'b01;
      OP_DOWN: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/updo_cmd_fifo.sv
// Synchronous command buffer. Push while full and pop while empty are ignored;
// a simultaneous push and pop leaves the occupancy unchanged.
module updo_cmd_fifo
  import updo_seq_pkg::*;
#(
  parameter int W     = $bits(cmd_t),
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/updo_stim_sequencer.sv
// Plays buffered {op,len} commands onto a 4-bit up/down counter's cnt_rst/updo
// pins and checks the returned count against a shadow model of the counter.
module updo_stim_sequencer
  import updo_seq_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cnt_rst,
  output logic             updo,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             cmd_done,
  output logic [CNT_W-1:0] exp_count,
  output logic             mismatch,
  output logic [ERR_W-1:0] mismatch_cnt,
  output logic             err_illegal
);

  localparam int               FW       = 2 + LEN_W;
  localparam logic [LEN_W-1:0] REM_LAST = LEN_W'(1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] shadow_step(input logic [CNT_W-1:0] v,
                                                   input logic r, input logic up);
    if (r)       return '0;
    else if (up) return v + 1'b1;
    else         return v - 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             updo_q, updo_d;
  logic [CNT_W-1:0] exp_q;
  logic             exp_valid_q;
  logic             mismatch_q;
  logic [ERR_W-1:0] mismatch_cnt_q;
  logic             err_illegal_q;

  logic             accept, is_ill, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_rdata;
  op_e              head_op;
  logic [LEN_W-1:0] head_len;

  // Illegal ops are consumed on the write side and never reach the buffer.
  assign cmd_ready = !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign is_ill    = (op_e'(cmd_op) == OP_ILL);
  assign fifo_push = accept && !is_ill;
  assign head_op   = op_e'(fifo_rdata[FW-1:LEN_W]);
  assign head_len  = fifo_rdata[LEN_W-1:0];

  updo_cmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_len}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // rem counts down to 1 on the last cycle; a loaded 0 wraps and yields 2**LEN_W cycles.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_rst_d = cnt_rst_q;
    updo_d    = updo_q;
    fifo_pop  = 1'b0;
    cmd_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_rst_d = 1'b1;
        updo_d    = 1'b0;
        if (!fifo_empty) begin
          fifo_pop              = 1'b1;
          state_d               = S_RUN;
          rem_d                 = head_len;
          {cnt_rst_d, updo_d}   = drive_for(head_op);
        end
      end
      S_RUN: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == REM_LAST) begin
          cmd_done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop            = 1'b1;
            rem_d               = head_len;
            {cnt_rst_d, updo_d} = drive_for(head_op);
          end else begin
            state_d   = S_IDLE;
            cnt_rst_d = 1'b1;
            updo_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rem_q          <= '0;
      cnt_rst_q      <= 1'b1;
      updo_q         <= 1'b0;
      exp_q          <= '0;
      exp_valid_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= '0;
      err_illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_rst_q <= cnt_rst_d;
      updo_q    <= updo_d;
      exp_q     <= shadow_step(exp_q, cnt_rst_q, updo_q);
      if (cnt_rst_q) exp_valid_q <= 1'b1;
      if (exp_valid_q && (count != exp_q)) begin
        mismatch_q     <= 1'b1;
        mismatch_cnt_q <= sat_inc(mismatch_cnt_q);
      end
      if (accept && is_ill) err_illegal_q <= 1'b1;
    end
  end

  assign cnt_rst      = cnt_rst_q;
  assign updo         = updo_q;
  assign busy         = (state_q == S_RUN) || !fifo_empty;
  assign exp_count    = exp_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign err_illegal  = err_illegal_q;

endmodule
